// File: rtl/usb_pkg.sv
// Shared types for the USB endpoint FIFO: per-side operation codes and
// their priority decode (abort/rewind beat commit, commit beats a bare push/pop).
package usb_pkg;

    typedef enum logic [1:0] {
        WR_NOP    = 2'd0,
        WR_PUSH   = 2'd1,
        WR_COMMIT = 2'd2,
        WR_ABORT  = 2'd3
    } fifo_wr_op_t;

    typedef enum logic [1:0] {
        RD_NOP    = 2'd0,
        RD_POP    = 2'd1,
        RD_COMMIT = 2'd2,
        RD_REWIND = 2'd3
    } fifo_rd_op_t;

    function automatic fifo_wr_op_t decode_wr_op(input logic wrreq, input logic wr_commit,
                                                 input logic wr_abort);
        fifo_wr_op_t op;
        if (wr_abort) begin
            op = WR_ABORT;
        end else if (wr_commit) begin
            op = WR_COMMIT;
        end else if (wrreq) begin
            op = WR_PUSH;
        end else begin
            op = WR_NOP;
        end
        return op;
    endfunction

    function automatic fifo_rd_op_t decode_rd_op(input logic rdreq, input logic rd_commit,
                                                 input logic rd_rewind);
        fifo_rd_op_t op;
        if (rd_rewind) begin
            op = RD_REWIND;
        end else if (rd_commit) begin
            op = RD_COMMIT;
        end else if (rdreq) begin
            op = RD_POP;
        end else begin
            op = RD_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/usb_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset only; otherwise it holds unless re is set.
module usb_fifo_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/usb_ep_fifo.sv
// Endpoint FIFO with packet-level transactions: speculative writes become visible
// on wr_commit (or vanish on wr_abort); speculative reads free space on rd_commit
// (or replay on rd_rewind).
module usb_ep_fifo
    import usb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  wr_commit,
    input  logic                  wr_abort,
    input  logic                  rdreq,
    input  logic                  rd_commit,
    input  logic                  rd_rewind,
    output logic [DATA_WIDTH-1:0] q,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PTR_W-1:0] AFULL_P = PTR_W'(AFULL_LEVEL);

    logic [PTR_W-1:0] wp_r, wb_r, rp_r, rb_r;
    logic             overflow_r, underflow_r;

    logic [PTR_W-1:0] usedw_s, occ_s, wp_next_s, rp_next_s;
    logic             empty_s, full_s, flush_s;
    logic             push_s, pop_s, ovf_s, unf_s;
    fifo_wr_op_t      wr_op_s;
    fifo_rd_op_t      rd_op_s;

    // Flags and accept decisions, all from pre-edge pointer state
    always_comb begin
        usedw_s   = wb_r - rp_r;
        occ_s     = wp_r - rb_r;
        empty_s   = (usedw_s == {PTR_W{1'b0}});
        full_s    = (occ_s == DEPTH_P);
        flush_s   = reset | sclr;
        wr_op_s   = decode_wr_op(wrreq, wr_commit, wr_abort);
        rd_op_s   = decode_rd_op(rdreq, rd_commit, rd_rewind);
        push_s    = wrreq & ~full_s & (wr_op_s != WR_ABORT) & ~flush_s;
        pop_s     = rdreq & ~empty_s & (rd_op_s != RD_REWIND) & ~flush_s;
        ovf_s     = wrreq & full_s & (wr_op_s != WR_ABORT);
        unf_s     = rdreq & empty_s & (rd_op_s != RD_REWIND);
        wp_next_s = wp_r + {{ADDR_WIDTH{1'b0}}, push_s};
        rp_next_s = rp_r + {{ADDR_WIDTH{1'b0}}, pop_s};
    end

    // Pointer and pulse registers; commits take the post-increment pointer
    always_ff @(posedge clk) begin
        if (reset || sclr) begin
            wp_r        <= {PTR_W{1'b0}};
            wb_r        <= {PTR_W{1'b0}};
            rp_r        <= {PTR_W{1'b0}};
            rb_r        <= {PTR_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_s;
            underflow_r <= unf_s;
            case (wr_op_s)
                WR_ABORT:  wp_r <= wb_r;
                WR_COMMIT: begin
                    wp_r <= wp_next_s;
                    wb_r <= wp_next_s;
                end
                WR_PUSH:   wp_r <= wp_next_s;
                default:   wp_r <= wp_r;
            endcase
            case (rd_op_s)
                RD_REWIND: rp_r <= rb_r;
                RD_COMMIT: begin
                    rp_r <= rp_next_s;
                    rb_r <= rp_next_s;
                end
                RD_POP:    rp_r <= rp_next_s;
                default:   rp_r <= rp_r;
            endcase
        end
    end

    // sclr keeps q because pop_s is gated off and the RAM only clears on reset
    usb_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push_s),
        .waddr (wp_r[ADDR_WIDTH-1:0]),
        .wdata (data),
        .re    (pop_s),
        .raddr (rp_r[ADDR_WIDTH-1:0]),
        .rdata (q)
    );

    assign usedw       = usedw_s;
    assign empty       = empty_s;
    assign full        = full_s;
    assign almost_full = (occ_s >= AFULL_P);
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule
